// File: rtl/attn_spikes_feeder.sv
// attn_spikes_feeder: transmit end of the attention-PE spike interface.
// Walks Query-row x Key-row x chunk loops (chunk innermost), reads the matching
// Q and K spike words from two 1-cycle-latency RAMs and presents them to the PE
// array as a valid-qualified pair tagged with row, column and chunk position.
// Ports:
//   s_clk, s_rst                 clock, synchronous active-low reset
//   i_start, i_q_rows/k_rows/chunks   job start pulse and R/C/K config
//   i_stall                      downstream almost-full, blocks new reads
//   o_busy, o_done               job status, one-cycle completion pulse
//   o_q_rd_*, i_q_rd_data        Query RAM read port
//   o_k_rd_*, i_k_rd_data        Key RAM read port
//   o_Spikesdata*, o_row_idx, o_col_idx, o_first_chunk, o_last_chunk  PE beat
module attn_spikes_feeder #(
  parameter int unsigned SYSTOLIC_UNIT_NUM = 8,
  parameter int unsigned TIME_STEPS        = 4,
  parameter int unsigned DATA_W            = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS,
  parameter int unsigned ADDR_W            = 12,
  parameter int unsigned CNT_W             = 8
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_q_rows,
  input  logic [CNT_W-1:0]  i_k_rows,
  input  logic [CNT_W-1:0]  i_chunks,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_q_rd_en,
  output logic [ADDR_W-1:0] o_q_rd_addr,
  input  logic [DATA_W-1:0] i_q_rd_data,
  output logic              o_k_rd_en,
  output logic [ADDR_W-1:0] o_k_rd_addr,
  input  logic [DATA_W-1:0] i_k_rd_data,
  output logic              o_Spikesdata_valid,
  output logic [DATA_W-1:0] o_SpikesdataQuery,
  output logic [DATA_W-1:0] o_SpikesdataKey,
  output logic [CNT_W-1:0]  o_row_idx,
  output logic [CNT_W-1:0]  o_col_idx,
  output logic              o_first_chunk,
  output logic              o_last_chunk
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cfg_r_q, cfg_r_d, cfg_c_q, cfg_c_d, cfg_k_q, cfg_k_d;
  logic [CNT_W-1:0]    row_q, row_d, col_q, col_d, chunk_q, chunk_d;
  logic [ADDR_W-1:0]   q_base_q, q_base_d, k_base_q, k_base_d;
  logic                valid_q, busy_q, done_q, first_q, last_q;
  logic [CNT_W-1:0]    row_tag_q, col_tag_q;
  logic [DATA_W-1:0]   q_hold_q, k_hold_q;

  logic                issue_c, last_chunk_c, last_col_c, final_c;

  // A read pair goes out in every unstalled RUN cycle.
  assign issue_c      = (state_q == ST_RUN) && !i_stall;
  assign last_chunk_c = (chunk_q == cfg_k_q - CNT_W'(1));
  assign last_col_c   = (col_q == cfg_c_q - CNT_W'(1));
  assign final_c      = last_chunk_c && last_col_c && (row_q == cfg_r_q - CNT_W'(1));

  // Next-state, config latch and loop counters with incremental address bases.
  always_comb begin
    state_d  = state_q;
    cfg_r_d  = cfg_r_q;
    cfg_c_d  = cfg_c_q;
    cfg_k_d  = cfg_k_q;
    row_d    = row_q;
    col_d    = col_q;
    chunk_d  = chunk_q;
    q_base_d = q_base_q;
    k_base_d = k_base_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cfg_r_d  = i_q_rows;
          cfg_c_d  = i_k_rows;
          cfg_k_d  = i_chunks;
          row_d    = '0;
          col_d    = '0;
          chunk_d  = '0;
          q_base_d = '0;
          k_base_d = '0;
          if ((i_q_rows == '0) || (i_k_rows == '0) || (i_chunks == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issue_c) begin
          if (final_c) begin
            state_d = ST_DRAIN;
          end
          if (last_chunk_c) begin
            chunk_d = '0;
            if (last_col_c) begin
              col_d    = '0;
              k_base_d = '0;
              row_d    = row_q + CNT_W'(1);
              q_base_d = q_base_q + ADDR_W'(cfg_k_q);
            end else begin
              col_d    = col_q + CNT_W'(1);
              k_base_d = k_base_q + ADDR_W'(cfg_k_q);
            end
          end else begin
            chunk_d = chunk_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters and the beat pipeline; reset also drops any in-flight beat.
  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      state_q   <= ST_IDLE;
      cfg_r_q   <= '0;
      cfg_c_q   <= '0;
      cfg_k_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      chunk_q   <= '0;
      q_base_q  <= '0;
      k_base_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      row_tag_q <= '0;
      col_tag_q <= '0;
      q_hold_q  <= '0;
      k_hold_q  <= '0;
    end else begin
      state_q  <= state_d;
      cfg_r_q  <= cfg_r_d;
      cfg_c_q  <= cfg_c_d;
      cfg_k_q  <= cfg_k_d;
      row_q    <= row_d;
      col_q    <= col_d;
      chunk_q  <= chunk_d;
      q_base_q <= q_base_d;
      k_base_q <= k_base_d;
      valid_q  <= issue_c;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      if (issue_c) begin
        row_tag_q <= row_q;
        col_tag_q <= col_q;
        first_q   <= (chunk_q == '0);
        last_q    <= last_chunk_c;
      end
      // Keep the last delivered words so the beat holds while valid is low.
      if (valid_q) begin
        q_hold_q <= i_q_rd_data;
        k_hold_q <= i_k_rd_data;
      end
    end
  end

  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_q_rd_en          = issue_c;
  assign o_k_rd_en          = issue_c;
  assign o_q_rd_addr        = q_base_q + ADDR_W'(chunk_q);
  assign o_k_rd_addr        = k_base_q + ADDR_W'(chunk_q);
  assign o_Spikesdata_valid = valid_q;
  // RAM output is already registered; pass it through on the valid beat.
  assign o_SpikesdataQuery  = valid_q ? i_q_rd_data : q_hold_q;
  assign o_SpikesdataKey    = valid_q ? i_k_rd_data : k_hold_q;
  assign o_row_idx          = row_tag_q;
  assign o_col_idx          = col_tag_q;
  assign o_first_chunk      = first_q;
  assign o_last_chunk       = last_q;

endmodule

// File: tb/tb_attn_spikes_feeder.sv
// Self-checking bench for attn_spikes_feeder: queue-based reference of the
// expected read and beat streams, RAM models, directed and randomized jobs.
module tb_attn_spikes_feeder;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CNT_W  = 8;

  logic              s_clk = 1'b0;
  logic              s_rst = 1'b0;
  logic              i_start = 1'b0;
  logic [CNT_W-1:0]  i_q_rows = '0, i_k_rows = '0, i_chunks = '0;
  logic              i_stall = 1'b0;
  logic              o_busy, o_done;
  logic              o_q_rd_en, o_k_rd_en;
  logic [ADDR_W-1:0] o_q_rd_addr, o_k_rd_addr;
  logic [DATA_W-1:0] i_q_rd_data, i_k_rd_data;
  logic              o_Spikesdata_valid;
  logic [DATA_W-1:0] o_SpikesdataQuery, o_SpikesdataKey;
  logic [CNT_W-1:0]  o_row_idx, o_col_idx;
  logic              o_first_chunk, o_last_chunk;

  attn_spikes_feeder dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start),
    .i_q_rows(i_q_rows), .i_k_rows(i_k_rows), .i_chunks(i_chunks),
    .i_stall(i_stall), .o_busy(o_busy), .o_done(o_done),
    .o_q_rd_en(o_q_rd_en), .o_q_rd_addr(o_q_rd_addr), .i_q_rd_data(i_q_rd_data),
    .o_k_rd_en(o_k_rd_en), .o_k_rd_addr(o_k_rd_addr), .i_k_rd_data(i_k_rd_data),
    .o_Spikesdata_valid(o_Spikesdata_valid),
    .o_SpikesdataQuery(o_SpikesdataQuery), .o_SpikesdataKey(o_SpikesdataKey),
    .o_row_idx(o_row_idx), .o_col_idx(o_col_idx),
    .o_first_chunk(o_first_chunk), .o_last_chunk(o_last_chunk)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    int qa; int ka; int row; int col; bit first; bit last;
  } beat_t;

  beat_t       iss_q[$];
  beat_t       beat_q[$];
  logic [63:0] qmem [0:4095];
  logic [63:0] kmem [0:4095];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          first_rd_cyc = -1;
  int          last_valid_cyc = -1;
  bit          job_nz = 1'b0;
  bit          mon_on = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge s_clk) cyc <= cyc + 1;

  // 1-cycle-latency RAMs; junk on the bus when not read exercises the hold path.
  always @(posedge s_clk) begin
    i_q_rd_data <= o_q_rd_en ? qmem[o_q_rd_addr] : {$urandom, $urandom};
    i_k_rd_data <= o_k_rd_en ? kmem[o_k_rd_addr] : {$urandom, $urandom};
  end

  // Monitor: every read and every beat must be the next one the loop nest predicts.
  always @(negedge s_clk) begin : mon
    beat_t e;
    if (mon_on) begin
      if (o_q_rd_en || o_k_rd_en) begin
        check_val("rd_pair", o_k_rd_en, o_q_rd_en);
        check_val("rd_in_stall", i_stall, 0);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (iss_q.size() == 0) check_val("rd_spurious", 1, 0);
        else begin
          e = iss_q.pop_front();
          check_val("q_addr", o_q_rd_addr, e.qa);
          check_val("k_addr", o_k_rd_addr, e.ka);
        end
      end
      if (o_Spikesdata_valid) begin
        last_valid_cyc = cyc;
        if (beat_q.size() == 0) check_val("beat_spurious", 1, 0);
        else begin
          e = beat_q.pop_front();
          check_val("q_word", o_SpikesdataQuery, qmem[e.qa]);
          check_val("k_word", o_SpikesdataKey, kmem[e.ka]);
          check_val("row_tag", o_row_idx, e.row);
          check_val("col_tag", o_col_idx, e.col);
          check_val("first_tag", o_first_chunk, e.first);
          check_val("last_tag", o_last_chunk, e.last);
        end
      end
      if (o_done && job_nz) check_val("done_lat", cyc - last_valid_cyc, 1);
    end
  end

  task automatic load_job(input int r, input int c, input int k);
    beat_t b;
    iss_q.delete();
    beat_q.delete();
    for (int ri = 0; ri < r; ri++)
      for (int ci = 0; ci < c; ci++)
        for (int ki = 0; ki < k; ki++) begin
          b.qa = (ri * k + ki) % 4096;
          b.ka = (ci * k + ki) % 4096;
          b.row = ri; b.col = ci;
          b.first = (ki == 0); b.last = (ki == k - 1);
          iss_q.push_back(b);
          beat_q.push_back(b);
        end
    job_nz = (r * c * k) != 0;
    first_rd_cyc = -1;
  endtask

  task automatic start_job(input int r, input int c, input int k, output int t);
    i_q_rows = CNT_W'(r); i_k_rows = CNT_W'(c); i_chunks = CNT_W'(k);
    @(posedge s_clk); #1;
    i_start = 1'b1;
    t = cyc;
    @(posedge s_clk); #1;
    i_start = 1'b0;
    // Config must have been latched; scramble it.
    i_q_rows = CNT_W'($urandom); i_k_rows = CNT_W'($urandom); i_chunks = CNT_W'($urandom);
  endtask

  task automatic wait_done(input bit rand_stall, input bit poke_start);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge s_clk); #1;
      i_stall = rand_stall && ($urandom_range(0, 3) == 0);
      i_start = poke_start && (i == 3);
      if (poke_start && i == 3) begin
        i_q_rows = 8'd1; i_k_rows = 8'd1; i_chunks = 8'd1;
      end
      @(negedge s_clk);
      if (o_done) seen = 1'b1;
    end
    i_stall = 1'b0;
    i_start = 1'b0;
    check_val("done_seen", seen, 1);
  endtask

  task automatic run_job(input int r, input int c, input int k, input bit rand_stall, input bit poke_start);
    int t;
    load_job(r, c, k);
    start_job(r, c, k, t);
    @(negedge s_clk);
    check_val("busy_run", o_busy, 1);
    wait_done(rand_stall, poke_start);
    check_val("first_rd_lat", first_rd_cyc - t, 1);
    check_val("issue_left", iss_q.size(), 0);
    check_val("beat_left", beat_q.size(), 0);
    @(negedge s_clk);
    check_val("done_1cyc", o_done, 0);
    check_val("idle_busy", o_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, o_busy, 0);
    check_val({tag, "_done"}, o_done, 0);
    check_val({tag, "_rd"}, {o_q_rd_en, o_k_rd_en}, 0);
    check_val({tag, "_addr"}, {o_q_rd_addr, o_k_rd_addr}, 0);
    check_val({tag, "_valid"}, o_Spikesdata_valid, 0);
    check_val({tag, "_qword"}, o_SpikesdataQuery, 0);
    check_val({tag, "_kword"}, o_SpikesdataKey, 0);
    check_val({tag, "_tags"}, {o_row_idx, o_col_idx, o_first_chunk, o_last_chunk}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int t, n;
    for (int i = 0; i < 4096; i++) begin
      qmem[i] = {$urandom, $urandom};
      kmem[i] = {$urandom, $urandom};
    end
    qmem[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    kmem[0] = 64'h3C3C_3C3C_3C3C_3C3C;

    repeat (3) @(posedge s_clk);
    #1 s_rst = 1'b1;
    mon_on = 1'b1;
    @(negedge s_clk);
    check_all_zero("reset");

    // Single beat, then a multi-row/col job.
    run_job(1, 1, 1, 1'b0, 1'b0);
    run_job(2, 3, 2, 1'b0, 1'b0);

    // Directed stall: 3 stall cycles after the 2nd read.
    load_job(1, 2, 4);
    start_job(1, 2, 4, t);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge s_clk);
      if (o_q_rd_en) n++;
    end
    check_val("stall_setup", n, 2);
    @(posedge s_clk); #1 i_stall = 1'b1;
    @(negedge s_clk);
    check_val("stall_c1_valid", o_Spikesdata_valid, 1);
    check_val("stall_c1_rd", o_q_rd_en, 0);
    @(negedge s_clk);
    check_val("stall_c2_valid", o_Spikesdata_valid, 0);
    @(negedge s_clk);
    check_val("stall_c3_valid", o_Spikesdata_valid, 0);
    @(posedge s_clk); #1 i_stall = 1'b0;
    wait_done(1'b0, 1'b0);
    check_val("stall_beats_left", beat_q.size(), 0);

    // Zero chunk count: immediate done, no reads.
    load_job(2, 3, 0);
    start_job(2, 3, 0, t);
    @(negedge s_clk);
    check_val("zero_done", o_done, 1);
    check_val("zero_rd", o_q_rd_en, 0);
    @(negedge s_clk);
    check_val("zero_done_1cyc", o_done, 0);

    // Start pulse while busy is ignored.
    run_job(2, 2, 2, 1'b0, 1'b1);

    // Reset after the 3rd read, then replay from address 0.
    load_job(2, 2, 2);
    start_job(2, 2, 2, t);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge s_clk);
      if (o_q_rd_en) n++;
    end
    check_val("rst_setup", n, 3);
    @(posedge s_clk); #1 s_rst = 1'b0;
    @(posedge s_clk); #1 s_rst = 1'b1;
    iss_q.delete();
    beat_q.delete();
    job_nz = 1'b0;
    @(negedge s_clk);
    check_all_zero("midrst");
    run_job(2, 2, 2, 1'b0, 1'b0);

    // Randomized jobs with random stalls.
    for (int j = 0; j < 12; j++)
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 4)), 1'b1, ($urandom_range(0, 1) == 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
